seq_divider_8b: RTL and testbench

SEQ_DIVIDER_8B -- requirements
Module: seq_divider_8b

---
 rtl/seq_divider_8b.sv | 176 +++++++++++++++++
 tb/tb_seq_divider_8b.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_8b.sv
// -----------------------------------------------------------------------------
// seq_divider_8b
// Sequential 8-bit by 4-bit unsigned restoring divider, one quotient bit
// per clock. FSM states: IDLE -> RUN (8 steps) -> DONE (one-cycle done pulse).
//
// Ports:
//   i_clk          clock, all state updates on its rising edge
//   i_reset        synchronous active-high reset
//   i_start        request pulse, sampled only while not busy
//   i_dividend[8]  unsigned dividend, captured on the accepted start
//   i_divisor[4]   unsigned divisor, captured on the accepted start
//   o_busy         high while a division is in progress
//   o_done         one-cycle pulse; results valid from this cycle on
//   o_quotient[8]  unsigned quotient
//   o_remainder[4] unsigned remainder
//   o_div_by_zero  zero-divisor flag (only ever set with DIV_ZERO_DETECT_EN)
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   When defined, a zero divisor skips RUN and finishes in one cycle with
//   quotient=8'hFF, remainder=4'hF, div_by_zero=1.
// -----------------------------------------------------------------------------
module seq_divider_8b (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_dividend,
    input  logic [3:0] i_divisor,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_quotient,
    output logic [3:0] o_remainder,
    output logic       o_div_by_zero
);

    localparam int unsigned DVD_W = 8;
    localparam int unsigned DVS_W = 4;
    localparam int unsigned REM_W = 5;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    // Low 4 bits of the 5-bit partial remainder; after each step the
    // remainder is below the divisor, so the top bit is always zero here.
    logic [DVS_W-1:0] r_prem;
    logic [DVD_W-1:0] r_dvd;
    logic [DVS_W-1:0] r_dvs;
    logic [DVD_W-1:0] r_quot;
    logic [DVS_W-1:0] r_rem;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [DVS_W-1:0] w_prem_nxt;
    logic [DVD_W-1:0] w_dvd_nxt;
    logic [DVS_W-1:0] w_dvs_nxt;
    logic [DVD_W-1:0] w_quot_nxt;
    logic [DVS_W-1:0] w_rem_nxt;
    logic             w_dbz_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic [REM_W-1:0] w_shift;
    logic             w_ge;
    logic [DVS_W-1:0] w_step_rem;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    // A successful subtraction always yields a value below 16, so 4-bit
    // arithmetic on the low bits gives the exact result.
    always_comb begin
        w_shift    = {r_prem, r_dvd[DVD_W-1]};
        w_ge       = (w_shift >= {1'b0, r_dvs});
        w_step_rem = w_ge ? (w_shift[DVS_W-1:0] - r_dvs) : w_shift[DVS_W-1:0];
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_prem_nxt  = r_prem;
        w_dvd_nxt   = r_dvd;
        w_dvs_nxt   = r_dvs;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_dbz_nxt   = r_dbz;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_dvd_nxt  = i_dividend;
                    w_dvs_nxt  = i_divisor;
                    w_cnt_nxt  = '0;
                    w_prem_nxt = '0;
                    w_dbz_nxt  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                    if (i_divisor == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_quot_nxt  = '1;
                        w_rem_nxt   = '1;
                        w_dbz_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_busy_nxt  = 1'b1;
                    end
`else
                    w_state_nxt = S_RUN;
                    w_busy_nxt  = 1'b1;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                // Quotient register doubles as the shift register for result bits.
                w_prem_nxt = w_step_rem;
                w_dvd_nxt  = {r_dvd[DVD_W-2:0], 1'b0};
                w_quot_nxt = {r_quot[DVD_W-2:0], w_ge};
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (r_cnt == '1) begin
                    w_state_nxt = S_DONE;
                    w_rem_nxt   = w_step_rem;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_prem  <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_prem  <= w_prem_nxt;
            r_dvd   <= w_dvd_nxt;
            r_dvs   <= w_dvs_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dbz   <= w_dbz_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_quotient    = r_quot;
    assign o_remainder   = r_rem;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_8b.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_8b
// Self-checking bench for seq_divider_8b: directed boundary cases, back-to-back
// and ignored starts, mid-run reset, zero divisor, then random operands.
// Expected results come from plain integer division in the bench.
// -----------------------------------------------------------------------------
module tb_seq_divider_8b;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider_8b dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one division and follow it to done; optionally pokes start mid-run.
    task automatic divide(input logic [7:0] a, input logic [3:0] d, input bit poke);
        logic [7:0] eq;
        logic [3:0] er;
        logic       edz;
        int         elat;
        int         lat;
        if (d != 4'd0) begin
            eq = 8'(int'(a) / int'(d));
            er = 4'(int'(a) % int'(d));
            edz = 1'b0;
            elat = 9;
        end else begin
`ifdef DIV_ZERO_DETECT_EN
            eq = 8'hFF; er = 4'hF; edz = 1'b1; elat = 1;
`else
            eq = 8'hFF; er = a[3:0]; edz = 1'b0; elat = 9;
`endif
        end
        start    = 1'b1;
        dividend = a;
        divisor  = d;
        step();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat = 1;
        while (!done && lat < 20) begin
            check("busy_run", 32'(busy), 32'd1);
            if (poke && lat == 4) begin
                start    = 1'b1;
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(elat));
        check("busy_done", 32'(busy), 32'd0);
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_by_zero", 32'(div_by_zero), 32'(edz));
        if (d != 4'd0) begin
            check("identity", 32'(int'(quotient) * int'(d) + int'(remainder)), 32'(a));
            check("rem_lt_div", 32'(remainder < d), 32'd1);
        end
    endtask

    // One idle cycle after done: pulse must drop and block must be idle.
    task automatic idle_check();
        start = 1'b0;
        step();
        check("done_drop", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen_done;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        step();
        start = 1'b1;   // reset must win over start
        step();
        start = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        step();

        divide(8'd200, 4'd7, 1'b0);
        idle_check();
        // Results hold while inputs wander.
        dividend = 8'd13;
        divisor  = 4'd2;
        repeat (3) step();
        check("hold_q", 32'(quotient), 32'd28);
        check("hold_r", 32'(remainder), 32'd4);

        divide(8'd255, 4'd1, 1'b0);  idle_check();
        divide(8'd255, 4'd15, 1'b0); idle_check();
        divide(8'd5, 4'd9, 1'b0);    idle_check();
        divide(8'd0, 4'd3, 1'b0);    idle_check();

        // Back-to-back: second start issued in the DONE cycle.
        divide(8'd200, 4'd7, 1'b0);
        divide(8'd100, 4'd10, 1'b0);
        idle_check();

        // Start poked during RUN is ignored.
        divide(8'd200, 4'd7, 1'b1);
        idle_check();

        // Reset in the middle of a run.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        step();
        start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_q", 32'(quotient), 32'd0);
        check("mrst_r", 32'(remainder), 32'd0);
        check("mrst_dbz", 32'(div_by_zero), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen_done = 1'b1;
            step();
        end
        check("mrst_no_done", 32'(seen_done), 32'd0);

        // Zero divisor, then a normal op must clear the flag.
        divide(8'd77, 4'd0, 1'b0);
        idle_check();
        divide(8'd9, 4'd3, 1'b0);
        idle_check();

        for (int i = 0; i < 1000; i++) begin
            divide(8'($urandom), 4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
